// File: rtl/md_ctrl_pkg.sv
// rtl/md_ctrl_pkg.sv - shared MD opcode and sequencer state encodings
package md_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } md_state_e;

  localparam int CNT_W = 4;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_lat_cnt.sv
// rtl/md_ctrl_lat_cnt.sv - loadable latency down-counter with ==1 flag
module md_lat_cnt
  import md_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so a stray decrement can never wrap into a long hang.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer: launch, busy/stall, HI/LO commit
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] E_md_op,
  input  logic       E_valid,
  input  logic       flush,
  input  logic       D_md_use,
  output logic       md_start,
  output logic [3:0] md_op,
  output logic       hilo_we,
  output logic       hi_we,
  output logic       lo_we,
  output logic       busy,
  output logic       stall_D
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  md_state_e        r_state;
  md_state_e        w_next;
  logic [3:0]       r_op;
  logic             w_issue;
  logic             w_go;
  logic [CNT_W-1:0] w_load_val;
  logic             w_cnt_one;

  // Reset wins over any E-stage request in the same cycle.
  assign w_issue    = (r_state == ST_IDLE) && E_valid && !flush && !rst;
  assign w_go       = w_issue && is_long_op(E_md_op);
  assign w_load_val = ((E_md_op == MD_MULT) || (E_md_op == MD_MULTU)) ? MUL_LOAD : DIV_LOAD;

  md_lat_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_go),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ST_RUN),
    .o_is_one   (w_cnt_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= MD_NONE;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_op <= E_md_op;
      end else if (r_state == ST_COMMIT) begin
        r_op <= MD_NONE;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    md_start = w_go;
    md_op    = w_go ? E_md_op : r_op;
    hilo_we  = 1'b0;
    hi_we    = w_issue && (E_md_op == MD_MTHI);
    lo_we    = w_issue && (E_md_op == MD_MTLO);
    busy     = (r_state != ST_IDLE);
    stall_D  = D_md_use && ((r_state != ST_IDLE) || w_go);
    case (r_state)
      ST_IDLE: begin
        // A one-cycle latency loads zero and goes straight to commit.
        if (w_go) w_next = (w_load_val == '0) ? ST_COMMIT : ST_RUN;
      end
      ST_RUN: begin
        if (w_cnt_one) w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        hilo_we = !rst;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - randomized and directed checks of md_ctrl against a cycle-window model
module tb_md_ctrl;

  localparam int MUL_L = 5;
  localparam int DIV_L = 10;
  localparam int LOGN  = 8192;

  logic       clk = 1'b0;
  logic       rst, E_valid, flush, D_md_use;
  logic [3:0] E_md_op;
  logic       md_start, hilo_we, hi_we, lo_we, busy, stall_D;
  logic [3:0] md_op;

  md_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk      (clk),
    .rst      (rst),
    .E_md_op  (E_md_op),
    .E_valid  (E_valid),
    .flush    (flush),
    .D_md_use (D_md_use),
    .md_start (md_start),
    .md_op    (md_op),
    .hilo_we  (hilo_we),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .busy     (busy),
    .stall_D  (stall_D)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  // Model: an operation started in cycle s with latency L occupies cycles s+1..s+L.
  int         m_start = -1;
  int         m_lat   = 0;
  logic [3:0] m_op    = 4'd0;

  logic lg_start [LOGN];
  logic lg_busy  [LOGN];
  logic lg_hilo  [LOGN];
  logic lg_stall [LOGN];
  logic lg_hi    [LOGN];
  logic lg_lo    [LOGN];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, t, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0b want %0b", nm, idx, act, exp);
    end
  endtask

  logic       e_run, e_go, e_hilo, e_hi, e_lo, e_stall, e_idle_req;
  logic [3:0] e_op;

  always @(negedge clk) begin
    e_run      = (m_start >= 0);
    e_idle_req = !rst && !e_run && E_valid && !flush;
    e_go       = e_idle_req && (E_md_op >= 4'd1) && (E_md_op <= 4'd4);
    e_hilo     = e_run && (t == m_start + m_lat) && !rst;
    e_hi       = e_idle_req && (E_md_op == 4'd7);
    e_lo       = e_idle_req && (E_md_op == 4'd8);
    e_stall    = D_md_use && (e_run || e_go);
    e_op       = e_go ? E_md_op : (e_run ? m_op : 4'd0);

    chk("md_start", {3'b0, md_start}, {3'b0, e_go});
    chk("md_op",    md_op,            e_op);
    chk("busy",     {3'b0, busy},     {3'b0, e_run});
    chk("hilo_we",  {3'b0, hilo_we},  {3'b0, e_hilo});
    chk("hi_we",    {3'b0, hi_we},    {3'b0, e_hi});
    chk("lo_we",    {3'b0, lo_we},    {3'b0, e_lo});
    chk("stall_D",  {3'b0, stall_D},  {3'b0, e_stall});

    if (t < LOGN) begin
      lg_start[t] = md_start;
      lg_busy[t]  = busy;
      lg_hilo[t]  = hilo_we;
      lg_stall[t] = stall_D;
      lg_hi[t]    = hi_we;
      lg_lo[t]    = lo_we;
    end

    if (rst) begin
      m_start = -1;
    end else if (e_go) begin
      m_start = t;
      m_lat   = (E_md_op <= 4'd2) ? MUL_L : DIV_L;
      m_op    = E_md_op;
    end else if (e_run && (t == m_start + m_lat)) begin
      m_start = -1;
    end
    t++;
  end

  task automatic drv(input logic r, input logic v, input logic f, input logic [3:0] op, input logic du);
    @(posedge clk);
    #1;
    rst      = r;
    E_valid  = v;
    flush    = f;
    E_md_op  = op;
    D_md_use = du;
  endtask

  int r0, t0, t1, t1_mtlo, t1_mult, t1_b2b, t1_lo, tf, th, th2, t2;

  initial begin
    rst = 1'b1; E_valid = 1'b0; flush = 1'b0; E_md_op = 4'd0; D_md_use = 1'b0;

    drv(1, 0, 0, 4'd0, 0);
    drv(1, 1, 0, 4'd1, 1); r0 = t;
    drv(0, 0, 0, 4'd0, 0);

    // MULT with an MFLO waiting in D for the whole operation.
    drv(0, 1, 0, 4'd1, 1); t0 = t;
    for (int k = 1; k <= 6; k++) drv(0, 0, 0, 4'd6, 1);
    drv(0, 0, 0, 4'd0, 0);

    // DIVU (divide by zero is sequenced the same), with MD ops offered while busy.
    drv(0, 1, 0, 4'd4, 0); t1 = t;
    drv(0, 0, 0, 4'd0, 0);
    drv(0, 0, 1, 4'd0, 0);
    drv(0, 1, 0, 4'd8, 0); t1_mtlo = t;
    drv(0, 1, 1, 4'd1, 0);
    drv(0, 1, 0, 4'd1, 0); t1_mult = t;
    for (int k = 0; k < 5; k++) drv(0, 0, 0, 4'd0, 0);
    drv(0, 1, 0, 4'd1, 0); t1_b2b = t;
    for (int k = 0; k < 6; k++) drv(0, 0, 0, 4'd0, 0);
    drv(0, 1, 0, 4'd8, 0); t1_lo = t;

    drv(0, 1, 1, 4'd3, 0); tf = t;
    drv(0, 0, 0, 4'd0, 0);
    drv(0, 1, 1, 4'd7, 0); th = t;
    drv(0, 1, 0, 4'd7, 0); th2 = t;

    // MULTU aborted by reset in its third busy cycle.
    drv(0, 1, 0, 4'd2, 0); t2 = t;
    drv(0, 0, 0, 4'd0, 0);
    drv(0, 0, 0, 4'd0, 0);
    drv(1, 0, 0, 4'd0, 0);
    for (int k = 0; k < 6; k++) drv(0, 0, 0, 4'd0, 0);

    for (int k = 0; k < 3000; k++) begin
      drv(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 8)),
          1'($urandom_range(0, 1)));
    end
    drv(0, 0, 0, 4'd0, 0);
    @(negedge clk);
    #1;

    lit("rst_blocks_go", r0, lg_start[r0], 1'b0);
    lit("busy_after_rst", r0 + 1, lg_busy[r0 + 1], 1'b0);
    for (int k = 0; k <= 7; k++) begin
      lit("mult_start", t0 + k, lg_start[t0 + k], k == 0);
      lit("mult_busy",  t0 + k, lg_busy[t0 + k], (k >= 1) && (k <= 5));
      lit("mult_hilo",  t0 + k, lg_hilo[t0 + k], k == 5);
      lit("mult_stall", t0 + k, lg_stall[t0 + k], k <= 5);
    end
    for (int k = 0; k <= 11; k++) begin
      lit("divu_busy", t1 + k, lg_busy[t1 + k], (k >= 1) && (k <= 10));
      lit("divu_hilo", t1 + k, lg_hilo[t1 + k], k == 10);
    end
    lit("mtlo_busy_lo", t1_mtlo, lg_lo[t1_mtlo], 1'b0);
    lit("mult_busy_start", t1_mult, lg_start[t1_mult], 1'b0);
    lit("b2b_start", t1_b2b, lg_start[t1_b2b], 1'b1);
    lit("b2b_offset", t1_b2b, 1'(t1_b2b - t1 == 11), 1'b1);
    lit("mtlo_idle_lo", t1_lo, lg_lo[t1_lo], 1'b1);
    lit("div_flush_start", tf, lg_start[tf], 1'b0);
    lit("div_flush_busy", tf + 1, lg_busy[tf + 1], 1'b0);
    lit("mthi_flush_hi", th, lg_hi[th], 1'b0);
    lit("mthi_hi", th2, lg_hi[th2], 1'b1);
    for (int k = 0; k <= 9; k++) begin
      lit("abort_hilo", t2 + k, lg_hilo[t2 + k], 1'b0);
      lit("abort_busy", t2 + k, lg_busy[t2 + k], (k >= 1) && (k <= 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port E_md_op  input  4  E-stage MD opcode (NONE/MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
REQ-006 SHALL have port E_valid  input  1  E-stage instruction valid.
REQ-007 SHALL have port flush  input  1  E-stage instruction killed this cycle.
REQ-008 SHALL have port D_md_use  input  1  D-stage instruction is any MD opcode other than NONE.
REQ-009 SHALL have port md_start  output  1  one-cycle launch pulse to MD datapath (operand capture).
REQ-010 SHALL have port md_op  output  4  opcode for the datapath: live E_md_op in the start cycle, latched copy while running.
REQ-011 SHALL have port hilo_we  output  1  one-cycle commit pulse; datapath writes HI and LO.
REQ-012 SHALL have port hi_we  output  1  MTHI write strobe.
REQ-013 SHALL have port lo_we  output  1  MTLO write strobe.
REQ-014 SHALL have port busy  output  1  operation in flight.
REQ-015 SHALL have port stall_D  output  1  freeze F/D and bubble E.

Function
REQ-016 SHALL implement FSM IDLE, RUN, COMMIT.
REQ-017 "go" = IDLE & E_valid & !flush & E_md_op in {MULT,MULTU,DIV,DIVU}.
REQ-018 md_start SHALL equal go combinationally; md_op SHALL equal E_md_op when go.
REQ-019 On go, SHALL latch op, load counter with LAT-1 (MUL_LAT or DIV_LAT) and enter RUN.
REQ-020 RUN SHALL decrement the counter each cycle and enter COMMIT when counter==1.
REQ-021 COMMIT SHALL assert hilo_we for exactly one cycle, then return to IDLE.
REQ-022 Start in cycle N SHALL give busy=1 in cycles N+1..N+LAT, hilo_we in cycle N+LAT, and IDLE in cycle N+LAT+1.
REQ-023 busy SHALL be 1 in RUN and COMMIT only.
REQ-024 stall_D SHALL equal D_md_use & (busy | md_start).
REQ-025 hi_we SHALL equal IDLE & E_valid & !flush & E_md_op==MTHI; lo_we likewise for MTLO.
REQ-026 MFHI/MFLO/NONE SHALL cause no state change and no strobe.
REQ-027 An MD opcode in E while busy SHALL be ignored: no start, no strobe, no counter change.
REQ-028 flush SHALL block go/hi_we/lo_we in its cycle only; flush in RUN/COMMIT SHALL NOT cancel the operation.
REQ-029 Divide-by-zero SHALL be sequenced identically (DIV_LAT cycles, commit issued).
REQ-030 Back-to-back: an MD op in E in cycle N+LAT+1 SHALL be accepted normally.
REQ-031 md_op SHALL hold the latched opcode through RUN/COMMIT and read NONE in IDLE when go=0.

Reset
REQ-032 rst SHALL force IDLE, counter=0, latched op=NONE; busy, hilo_we, md_start, hi_we, lo_we, stall_D all 0 the following cycle.
REQ-033 rst in RUN or COMMIT SHALL abort with no hilo_we pulse.
REQ-034 rst SHALL dominate go and flush in the same cycle.

Structure
REQ-035 Opcode encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8) and FSM state encodings SHALL live in the shared MD definitions header, shared with the MD datapath.
REQ-036 The down-counter SHALL be one sub-module, md_lat_cnt (load value, load enable, decrement, ==1 flag), 4 bits wide.

Verification
REQ-037 MULT in E at cycle 0 (E_valid=1) -> md_start=1 at 0; busy=1 at 1..5; hilo_we=1 at 5 only; IDLE at 6.
REQ-038 DIVU with B=0 at cycle 0 -> busy at 1..10; hilo_we at 10; no hang.
REQ-039 MULT at 0 and MFLO in D at 0..5 -> stall_D=1 at cycles 0..5 and 0 at 6.
REQ-040 DIV with flush=1 at cycle 0 -> no md_start, busy stays 0; MTHI with flush=1 -> hi_we=0.
REQ-041 MULTU at 0, rst=1 at cycle 3 -> busy=0 from 4; hilo_we never pulses.
REQ-042 MTLO in E while busy (forced) -> lo_we=0, counter unchanged; MTLO in IDLE -> lo_we=1 same cycle.
